// File: rtl/radar_sim_pkg.sv
// Shared radar-simulation constants and helpers used by the azimuth generator and capture blocks.
package radar_sim_pkg;

  localparam int DEF_WORD = 32;
  localparam int DEF_SIZE = 3200;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CAPTURE = 1'b1
  } cap_state_t;

  // Bits needed to hold the values 0..value-1, never less than one.
  function automatic int clogb2(input int value);
    int v;
    int w;
    v = value - 1;
    w = 0;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/capture_word_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible the cycle after the push edge.
// Push into a full FIFO is accepted only when a pop happens in the same cycle; output reads 0 while empty.
module capture_word_fifo
  import radar_sim_pkg::*;
#(
  parameter int DW    = 33,
  parameter int DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_dat,
  input  logic          i_pop,
  output logic [DW-1:0] o_dat,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = clogb2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_push_dat;
  end

  // Gating with empty keeps the stream outputs at zero after reset or flush.
  assign o_dat = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/azimuth_signal_capture.sv
// Samples SIG_IN on each CLK_PE after TRIG and packs a SIZE-cell sweep into WORD-bit stream words, LSB = lowest cell.
// A word reaches M_TVALID one cycle after its completing CLK_PE; a full FIFO drops the word and sets OVERRUN.
module azimuth_signal_capture
  import radar_sim_pkg::*;
#(
  parameter int SIZE       = DEF_SIZE,
  parameter int WORD       = DEF_WORD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            SYS_CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic            TRIG,
  input  logic            CLK_PE,
  input  logic            SIG_IN,
  output logic [WORD-1:0] M_TDATA,
  output logic            M_TVALID,
  input  logic            M_TREADY,
  output logic            M_TLAST,
  output logic            BUSY,
  output logic            OVERRUN,
  output logic            ABORTED
);

  localparam int NW  = (SIZE + WORD - 1) / WORD;
  localparam int CW  = clogb2(SIZE);
  localparam int NWW = clogb2(NW);
  localparam int BW  = clogb2(WORD);

  cap_state_t      r_state;
  cap_state_t      w_state_nxt;
  logic [CW-1:0]   r_k;
  logic [BW-1:0]   r_bit;
  logic [NWW-1:0]  r_widx;
  logic [WORD-1:0] r_shift;
  logic            r_overrun;
  logic            r_aborted;

  logic            w_start;
  logic            w_abort;
  logic            w_sample;
  logic            w_last_cell;
  logic            w_word_done;
  logic            w_word_last;
  logic [WORD-1:0] w_word;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_flush;
  logic            w_full;
  logic            w_empty;
  logic [WORD:0]   w_fifo_dat;

  assign w_start     = (r_state == ST_IDLE) && EN && TRIG;
  assign w_abort     = (r_state == ST_CAPTURE) && EN && TRIG;
  assign w_sample    = (r_state == ST_CAPTURE) && EN && CLK_PE && !TRIG;
  assign w_last_cell = (r_k == CW'(SIZE - 1));
  assign w_word_done = w_sample && ((r_bit == BW'(WORD - 1)) || w_last_cell);
  assign w_word_last = (r_widx == NWW'(NW - 1));

  always_comb begin
    w_word        = r_shift;
    w_word[r_bit] = SIG_IN;
  end

  assign w_pop   = M_TVALID && M_TREADY;
  assign w_push  = w_word_done && (!w_full || w_pop);
  assign w_drop  = w_word_done && w_full && !w_pop;
  assign w_flush = !EN || w_abort;

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (EN && TRIG) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!EN)                           w_state_nxt = ST_IDLE;
        else if (TRIG)                     w_state_nxt = ST_CAPTURE;
        else if (w_sample && w_last_cell)  w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      r_k       <= '0;
      r_bit     <= '0;
      r_widx    <= '0;
      r_shift   <= '0;
      r_overrun <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= w_abort;
      if (w_start || w_abort) begin
        r_k     <= '0;
        r_bit   <= '0;
        r_widx  <= '0;
        r_shift <= '0;
      end else if (w_sample) begin
        r_k <= w_last_cell ? '0 : r_k + 1'b1;
        if (w_word_done) begin
          // Cleared shift word guarantees zero padding above the last cell.
          r_shift <= '0;
          r_bit   <= '0;
          r_widx  <= w_word_last ? '0 : r_widx + 1'b1;
        end else begin
          r_shift <= w_word;
          r_bit   <= r_bit + 1'b1;
        end
      end
      if (w_start || w_abort) r_overrun <= 1'b0;
      else if (w_drop)        r_overrun <= 1'b1;
    end
  end

  capture_word_fifo #(
    .DW    (WORD + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (SYS_CLK),
    .i_rst      (RST),
    .i_flush    (w_flush),
    .i_push     (w_push),
    .i_push_dat ({w_word_last, w_word}),
    .i_pop      (w_pop),
    .o_dat      (w_fifo_dat),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign M_TVALID = !w_empty;
  assign M_TDATA  = w_fifo_dat[WORD-1:0];
  assign M_TLAST  = w_fifo_dat[WORD];
  assign BUSY     = (r_state == ST_CAPTURE);
  assign OVERRUN  = r_overrun;
  assign ABORTED  = r_aborted;

endmodule

// File: tb/tb_azimuth_signal_capture.sv
// Self-checking bench for azimuth_signal_capture with a 136-cell sweep (five words, partial last word).
module tb_azimuth_signal_capture;

  localparam int SIZE  = 136;
  localparam int WORD  = 32;
  localparam int DEPTH = 4;
  localparam int NW    = (SIZE + WORD - 1) / WORD;

  logic            SYS_CLK = 1'b0;
  logic            RST = 1'b0;
  logic            EN = 1'b0;
  logic            TRIG = 1'b0;
  logic            CLK_PE = 1'b0;
  logic            SIG_IN = 1'b0;
  logic            M_TREADY = 1'b0;
  logic [WORD-1:0] M_TDATA;
  logic            M_TVALID;
  logic            M_TLAST;
  logic            BUSY;
  logic            OVERRUN;
  logic            ABORTED;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WORD-1:0] got_dat[$];
  logic            got_last[$];
  bit              cells[SIZE];
  bit              rnd_ready = 1'b0;

  typedef struct {
    int          pat;
    int          gap;
    logic [31:0] w0;
    logic [31:0] wl;
  } vec_t;

  vec_t vecs[4];

  always #5 SYS_CLK = ~SYS_CLK;

  azimuth_signal_capture #(
    .SIZE       (SIZE),
    .WORD       (WORD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .SYS_CLK  (SYS_CLK),
    .RST      (RST),
    .EN       (EN),
    .TRIG     (TRIG),
    .CLK_PE   (CLK_PE),
    .SIG_IN   (SIG_IN),
    .M_TDATA  (M_TDATA),
    .M_TVALID (M_TVALID),
    .M_TREADY (M_TREADY),
    .M_TLAST  (M_TLAST),
    .BUSY     (BUSY),
    .OVERRUN  (OVERRUN),
    .ABORTED  (ABORTED)
  );

  // Every handshake seen here completes on the following rising edge.
  always @(negedge SYS_CLK) begin
    if (!RST && M_TVALID && M_TREADY) begin
      got_dat.push_back(M_TDATA);
      got_last.push_back(M_TLAST);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
    if (rnd_ready) M_TREADY = ($urandom_range(0, 3) != 0);
  endtask

  function automatic bit cell_val(input int pat, input int k);
    case (pat)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (k % 2) == 0;
      3:       return (k % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Expected {last, data} for word w from the recorded cell values.
  function automatic logic [WORD:0] exp_word(input int w);
    logic [WORD:0] r;
    r = '0;
    for (int b = 0; b < WORD; b++) begin
      if (w * WORD + b < SIZE) r[b] = cells[w * WORD + b];
    end
    r[WORD] = (w == NW - 1);
    return r;
  endfunction

  task automatic clear_got();
    got_dat.delete();
    got_last.delete();
  endtask

  task automatic do_trig();
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
  endtask

  task automatic drive_cells(input int pat, input int first, input int count, input int gap);
    for (int k = first; k < first + count; k++) begin
      cells[k] = cell_val(pat, k);
      SIG_IN   = cells[k];
      CLK_PE   = 1'b1;
      tick();
      CLK_PE   = 1'b0;
      SIG_IN   = 1'b0;
      if (gap < 0) repeat ($urandom_range(0, 3)) tick();
      else         repeat (gap) tick();
    end
  endtask

  task automatic wait_words(input string name, input int n, input int budget);
    int t;
    t = 0;
    while (got_dat.size() < n && t < budget) begin
      tick();
      t++;
    end
    repeat (8) tick();
    check(name, 64'(got_dat.size()), 64'(n));
  endtask

  task automatic check_words(input string name);
    for (int w = 0; w < NW && w < got_dat.size(); w++)
      check(name, {got_last[w], got_dat[w]}, exp_word(w));
  endtask

  initial begin
    vecs[0] = '{1, 0, 32'hFFFF_FFFF, 32'h0000_00FF};
    vecs[1] = '{2, 1, 32'h5555_5555, 32'h0000_0055};
    vecs[2] = '{0, 2, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{3, 0, 32'h4924_9249, 32'h0000_0092};

    #2 RST = 1'b1;
    repeat (3) tick();
    check("rst_tdata",   64'(M_TDATA),  64'd0);
    check("rst_tvalid",  64'(M_TVALID), 64'd0);
    check("rst_tlast",   64'(M_TLAST),  64'd0);
    check("rst_busy",    64'(BUSY),     64'd0);
    check("rst_overrun", 64'(OVERRUN),  64'd0);
    check("rst_aborted", 64'(ABORTED),  64'd0);
    RST = 1'b0;
    EN  = 1'b1;
    tick();

    // Table-driven full sweeps with an always-ready sink.
    for (int i = 0; i < 4; i++) begin
      clear_got();
      M_TREADY = 1'b1;
      do_trig();
      check("vec_busy_on", 64'(BUSY), 64'd1);
      drive_cells(vecs[i].pat, 0, SIZE, vecs[i].gap);
      wait_words("vec_count", NW, 200);
      if (got_dat.size() == NW) begin
        check("vec_word0", 64'(got_dat[0]), 64'(vecs[i].w0));
        check("vec_wordlast", 64'(got_dat[NW-1]), 64'(vecs[i].wl));
      end
      check_words("vec_model");
      check("vec_overrun", 64'(OVERRUN), 64'd0);
      check("vec_busy_off", 64'(BUSY), 64'd0);
    end

    // Random cells, random CLK_PE spacing and random sink readiness.
    for (int s = 0; s < 3; s++) begin
      clear_got();
      do_trig();
      rnd_ready = 1'b1;
      drive_cells(4, 0, SIZE, -1);
      rnd_ready = 1'b0;
      M_TREADY  = 1'b1;
      wait_words("rnd_count", NW, 300);
      check_words("rnd_model");
      check("rnd_overrun", 64'(OVERRUN), 64'd0);
    end

    // Backpressure: four words fill the FIFO, the fifth is dropped.
    clear_got();
    M_TREADY = 1'b0;
    do_trig();
    drive_cells(3, 0, 4 * WORD, 0);
    check("bp_tvalid", 64'(M_TVALID), 64'd1);
    check("bp_head", 64'(M_TDATA), 64'(exp_word(0)));
    check("bp_no_ovr_yet", 64'(OVERRUN), 64'd0);
    repeat (5) tick();
    check("bp_head_stable", {M_TLAST, M_TDATA}, exp_word(0));
    drive_cells(3, 4 * WORD, SIZE - 4 * WORD, 0);
    check("bp_overrun", 64'(OVERRUN), 64'd1);
    check("bp_busy_off", 64'(BUSY), 64'd0);
    M_TREADY = 1'b1;
    wait_words("bp_drain_count", 4, 50);
    for (int w = 0; w < 4 && w < got_dat.size(); w++)
      check("bp_drain_word", {got_last[w], got_dat[w]}, exp_word(w));
    check("bp_empty", 64'(M_TVALID), 64'd0);
    check("bp_ovr_sticky", 64'(OVERRUN), 64'd1);

    // Restart by TRIG coinciding with CLK_PE after 50 cells.
    clear_got();
    M_TREADY = 1'b0;
    do_trig();
    check("ab_ovr_cleared", 64'(OVERRUN), 64'd0);
    drive_cells(2, 0, 50, 0);
    check("ab_word_held", 64'(M_TVALID), 64'd1);
    TRIG   = 1'b1;
    CLK_PE = 1'b1;
    SIG_IN = 1'b1;
    tick();
    TRIG   = 1'b0;
    CLK_PE = 1'b0;
    SIG_IN = 1'b0;
    check("ab_pulse", 64'(ABORTED), 64'd1);
    check("ab_flushed", 64'(M_TVALID), 64'd0);
    check("ab_busy", 64'(BUSY), 64'd1);
    tick();
    check("ab_pulse_end", 64'(ABORTED), 64'd0);
    M_TREADY = 1'b1;
    drive_cells(3, 0, SIZE, 0);
    wait_words("ab_count", NW, 200);
    check_words("ab_model");

    // TRIG with CLK_PE in IDLE must not consume a cell; CLK_PE after the sweep is ignored.
    clear_got();
    TRIG   = 1'b1;
    CLK_PE = 1'b1;
    SIG_IN = 1'b1;
    tick();
    TRIG   = 1'b0;
    CLK_PE = 1'b0;
    SIG_IN = 1'b0;
    check("idle_trig_busy", 64'(BUSY), 64'd1);
    drive_cells(0, 0, SIZE, 0);
    wait_words("idle_count", NW, 200);
    check_words("idle_model");
    clear_got();
    drive_cells(1, 0, 40, 0);
    repeat (10) tick();
    check("post_sweep_words", 64'(got_dat.size()), 64'd0);
    check("post_sweep_busy", 64'(BUSY), 64'd0);

    // EN low flushes and ignores TRIG.
    M_TREADY = 1'b0;
    do_trig();
    drive_cells(1, 0, 40, 0);
    check("en_word_held", 64'(M_TVALID), 64'd1);
    EN = 1'b0;
    tick();
    check("en_flushed", 64'(M_TVALID), 64'd0);
    check("en_idle", 64'(BUSY), 64'd0);
    do_trig();
    check("en_trig_ignored", 64'(BUSY), 64'd0);
    EN = 1'b1;
    tick();

    // Asynchronous reset mid-sweep with a word waiting.
    clear_got();
    do_trig();
    drive_cells(1, 0, 40, 0);
    check("rst2_pre_valid", 64'(M_TVALID), 64'd1);
    #2 RST = 1'b1;
    #1;
    check("rst2_tvalid",  64'(M_TVALID), 64'd0);
    check("rst2_tdata",   64'(M_TDATA),  64'd0);
    check("rst2_tlast",   64'(M_TLAST),  64'd0);
    check("rst2_busy",    64'(BUSY),     64'd0);
    check("rst2_overrun", 64'(OVERRUN),  64'd0);
    tick();
    RST = 1'b0;
    tick();
    M_TREADY = 1'b1;
    do_trig();
    drive_cells(2, 0, SIZE, 0);
    wait_words("rst2_count", NW, 200);
    check_words("rst2_model");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/azimuth_signal_capture.md
# azimuth_signal_capture

Capture-side counterpart of the azimuth signal generator. Samples a serial per-range-cell signal on the same TRIG / CLK_PE timing the generator uses and packs one sweep of SIZE cells into WORD-bit words on an AXI4-Stream-style master port, LSB = lowest cell. Used for loopback self-test of the generator path and for recording the received video bitmap back to the PS.

## Interface
- SIZE, 3200, range cells per sweep (≥1)
- WORD, 32, stream word width (power of 2, ≥8)
- FIFO_DEPTH, 4, output word FIFO depth (power of 2, ≥2)
- SYS_CLK  in  1  system clock, 100 MHz
- RST  in  1  reset, asynchronous, active-high
- EN  in  1  block enable
- TRIG  in  1  sweep start pulse (one SYS_CLK cycle)
- CLK_PE  in  1  range-cell advance strobe (one SYS_CLK cycle)
- SIG_IN  in  1  serial cell signal (e.g. generator GEN_SIGNAL)
- M_TDATA  out  WORD  packed cells; bit b of word w = cell w*WORD+b
- M_TVALID  out  1  word valid
- M_TREADY  in  1  downstream accept
- M_TLAST  out  1  high on last word of sweep (word NW-1)
- BUSY  out  1  high while in CAPTURE
- OVERRUN  out  1  sticky: word dropped because FIFO full
- ABORTED  out  1  one-cycle pulse: sweep restarted before completion

## Operation
- NW = ceil(SIZE/WORD) words per sweep; cell counter width clogb2(SIZE), word counter width clogb2(NW).
- States: IDLE, CAPTURE.
- IDLE: EN && TRIG → CAPTURE; cell index k=0, shift word cleared, OVERRUN cleared.
- CAPTURE, cycle with CLK_PE=1 and TRIG=0: SIG_IN stored as cell k (bit k mod WORD), k increments. Cell k is thus the value present while the generator index equals k.
- Word completes when k mod WORD = WORD-1 or k = SIZE-1; word pushed to FIFO with TLAST = (word index = NW-1). Unused upper bits of final word are 0.
- After cell SIZE-1: → IDLE; further CLK_PE ignored until next TRIG.
- TRIG in CAPTURE (including same cycle as a CLK_PE): TRIG wins, CLK_PE ignored, partial word discarded, FIFO flushed, ABORTED pulses, capture restarts at k=0 (stays CAPTURE).
- FIFO full at push: word dropped, OVERRUN set; remaining sweep words still captured and pushed if space.
- EN low: next edge → IDLE, FIFO flushed, M_TVALID low; TRIG/CLK_PE ignored.
- Stream rule: once M_TVALID high, M_TDATA/M_TLAST held stable until M_TREADY sampled high; transfer on VALID&&READY.

## Timing
- Reset values: M_TDATA 0, M_TVALID 0, M_TLAST 0, BUSY 0, OVERRUN 0, ABORTED 0; state IDLE, FIFO empty.
- BUSY high the edge after accepted TRIG; low the edge after cell SIZE-1 sampled.
- Latency: completing CLK_PE in cycle c → word in FIFO at edge ending c → M_TVALID high in c+1 if FIFO was empty (1 cycle).
- FIFO supports push and pop in the same cycle when full (pop frees slot; no overrun).
- ABORTED and OVERRUN registered; OVERRUN holds until next sweep-starting TRIG or RST.
- RST mid-sweep: immediate return to reset values; no partial output.

## Structure
- Shared package radar_sim_pkg: clogb2 function, default WORD and SIZE constants (shared with the generator).
- Sub-module capture_word_fifo: synchronous FIFO, WORD+1 bits (data+last), FIFO_DEPTH, synchronous flush, full/empty flags, first-word-fall-through output.
- Top: FSM, cell/word counters, shift word register, flags.

## Test plan
- Loopback SIZE=3200, WORD=32: generator DATA = alternating 0x55..., shared TRIG, CLK_PE every 10 cycles, TREADY=1 → 100 words of 0x55555555, TLAST only on word 99, OVERRUN=0.
- SIZE=40, SIG_IN=1 all cells → word0 0xFFFFFFFF, word1 0x000000FF with TLAST.
- Backpressure: SIZE=3200, TREADY=0, FIFO_DEPTH=4 → 4 words held stable, OVERRUN set at word 5 completion; TREADY=1 later drains exactly 4 words.
- TRIG after 50 cells, same cycle as a CLK_PE → ABORTED one pulse, FIFO empty, next sweep delivers full 100 words from cell 0.
- TRIG with CLK_PE in IDLE → k=0 on next CLK_PE; CLK_PE after sweep end with no TRIG → no words.
- RST asserted mid-sweep with M_TVALID high → all outputs 0 asynchronously; next TRIG gives clean sweep.
